// File: rtl/accel_pkg.sv
// Shared accelerator types: memory geometry, fetch sequencer state and beat payload.
package accel_pkg;

  localparam int unsigned VECTOR_WIDTH = 32;
  localparam int unsigned MATRIX_DIM   = 16;
  localparam int unsigned IDX_W        = 4;
  localparam int unsigned UNIT_W       = 2;
  localparam int unsigned MAT_W        = 2;
  localparam int unsigned ROWS_W       = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } fetch_state_t;

  typedef struct packed {
    logic [VECTOR_WIDTH-1:0] vec;
    logic [MAT_W-1:0]        mat;
    logic [IDX_W-1:0]        row;
    logic [IDX_W-1:0]        col;
    logic                    last_col;
    logic                    last;
  } fetch_beat_t;

endpackage

// File: rtl/matvec_fetch_sequencer_skid_buffer.sv
// Two-entry FIFO of fetch beats absorbing the memory read latency ahead of the consumer.
module fetch_skid_buffer
  import accel_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        push,
  input  fetch_beat_t push_data,
  input  logic        pop,
  output fetch_beat_t head,
  output logic [1:0]  count
);

  fetch_beat_t slots [2];
  logic        rd_ptr;
  logic        wr_ptr;
  logic        pop_ok;

  assign pop_ok = pop && (count != 2'd0);
  assign head   = slots[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slots[0] <= '0;
      slots[1] <= '0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        slots[wr_ptr] <= push_data;
        wr_ptr        <= ~wr_ptr;
      end
      if (pop_ok) rd_ptr <= ~rd_ptr;
      case ({push, pop_ok})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // The issue throttle upstream guarantees a free slot for every returning read.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && !pop_ok && !flush && (count == 2'd2)));

endmodule

// File: rtl/matvec_fetch_sequencer.sv
// Walks a band of matrix rows column by column, issuing paired vector/matrix reads
// and streaming one valid/ready beat per matrix element.
module matvec_fetch_sequencer
  import accel_pkg::*;
#(
  parameter int unsigned VEC_W = VECTOR_WIDTH,
  parameter int unsigned DIM   = MATRIX_DIM
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       unit_id,
  input  logic [3:0]       row_start,
  input  logic [4:0]       row_count,
  input  logic             abort,
  output logic             idle,
  output logic             done,
  output logic             err,
  output logic [5:0]       mem_addr_a,
  output logic             mem_we_a,
  output logic [7:0]       mem_addr_b,
  output logic             mem_we_b,
  input  logic             mem_busy,
  input  logic [1:0]       mem_error,
  input  logic [VEC_W-1:0] mem_data_a,
  input  logic [1:0]       mem_data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [VEC_W-1:0] out_vec,
  output logic [1:0]       out_mat,
  output logic [3:0]       out_row,
  output logic [3:0]       out_col,
  output logic             out_last_col,
  output logic             out_last
);

  localparam logic [IDX_W-1:0] LAST_COL = IDX_W'(DIM - 1);

  fetch_state_t        state, state_next;
  logic [UNIT_W-1:0]   unit_q;
  logic [IDX_W-1:0]    row_q;
  logic [IDX_W-1:0]    col_q;
  logic [ROWS_W-1:0]   rows_left;
  logic                inflight;
  logic [IDX_W-1:0]    tag_row;
  logic [IDX_W-1:0]    tag_col;
  logic                tag_last_col;
  logic                tag_last;
  logic [1:0]          count;
  fetch_beat_t         head;
  fetch_beat_t         push_beat;
  logic [2:0]          occupancy;
  logic                accept, issue, flush, pop, push, room, last_issue, drained;

  assign mem_addr_a = {unit_q, col_q};
  assign mem_addr_b = {row_q, col_q};
  assign mem_we_a   = 1'b0;
  assign mem_we_b   = 1'b0;

  assign out_valid    = (count != 2'd0);
  assign out_vec      = VEC_W'(head.vec);
  assign out_mat      = head.mat;
  assign out_row      = head.row;
  assign out_col      = head.col;
  assign out_last_col = head.last_col;
  assign out_last     = head.last;

  assign pop       = out_valid && out_ready;
  assign push      = inflight && !flush;
  assign occupancy = 3'(count) + 3'(inflight);

  always_comb begin
    push_beat          = '0;
    push_beat.vec      = VECTOR_WIDTH'(mem_data_a);
    push_beat.mat      = mem_data_b;
    push_beat.row      = tag_row;
    push_beat.col      = tag_col;
    push_beat.last_col = tag_last_col;
    push_beat.last     = tag_last;
  end

  // Next-state and control decode; abort overrides everything outside IDLE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    flush      = 1'b0;
    room       = (occupancy <= 3'd1) || ((occupancy == 3'd2) && pop);
    last_issue = (rows_left == ROWS_W'(1)) && (col_q == LAST_COL);
    drained    = !inflight && ((count == 2'd0) || ((count == 2'd1) && pop));
    case (state)
      IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = (row_count == '0) ? DONE : FETCH;
        end
      end
      FETCH: begin
        if (!mem_busy && room) begin
          issue = 1'b1;
          if (last_issue) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (drained) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (abort && (state != IDLE)) begin
      state_next = IDLE;
      issue      = 1'b0;
      flush      = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idle  <= 1'b1;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      idle  <= (state_next == IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Read pointer doubles as the registered address; it advances only on issue.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      unit_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      rows_left <= '0;
    end else if (accept) begin
      unit_q    <= unit_id;
      row_q     <= row_start;
      col_q     <= '0;
      rows_left <= row_count;
    end else if (issue) begin
      col_q <= col_q + IDX_W'(1);
      if (col_q == LAST_COL) begin
        row_q     <= row_q + IDX_W'(1);
        rows_left <= rows_left - ROWS_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight     <= 1'b0;
      tag_row      <= '0;
      tag_col      <= '0;
      tag_last_col <= 1'b0;
      tag_last     <= 1'b0;
    end else begin
      inflight <= issue;
      if (issue) begin
        tag_row      <= row_q;
        tag_col      <= col_q;
        tag_last_col <= (col_q == LAST_COL);
        tag_last     <= last_issue;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err <= 1'b0;
    end else if (accept) begin
      err <= 1'b0;
    end else if (push && (mem_error != 2'b00)) begin
      err <= 1'b1;
    end
  end

  fetch_skid_buffer u_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .push      (push),
    .push_data (push_beat),
    .pop       (pop),
    .head      (head),
    .count     (count)
  );

endmodule
